// File: rtl/vga_timing_if.sv
// Video timing bundle: position counters plus sync/blank/frame markers
// describing a single pixel. The generator drives it, draw stages consume it.
interface vga_timing_if;
  logic [10:0] hcount_out;
  logic [10:0] vcount_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        hblnk_out;
  logic        vblnk_out;
  logic        frame_start_out;

  modport master (
    output hcount_out,
    output vcount_out,
    output hsync_out,
    output vsync_out,
    output hblnk_out,
    output vblnk_out,
    output frame_start_out
  );

  modport slave (
    input hcount_out,
    input vcount_out,
    input hsync_out,
    input vsync_out,
    input hblnk_out,
    input vblnk_out,
    input frame_start_out
  );
endinterface

// File: rtl/vga_timing.sv
// Free-running raster timing generator (1024x768@60 on 65 MHz by default).
// Every output is a register loaded from the decode of the *next* counter
// values, so counters, syncs, blanks and frame_start all describe the same
// pixel in the same cycle with no combinational path to the outputs.
module vga_timing #(
  parameter int   H_VISIBLE = 1024,
  parameter int   H_FRONT   = 24,
  parameter int   H_SYNC    = 136,
  parameter int   H_BACK    = 160,
  parameter int   V_VISIBLE = 768,
  parameter int   V_FRONT   = 3,
  parameter int   V_SYNC    = 6,
  parameter int   V_BACK    = 29,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0
) (
  input  logic          pclk,
  input  logic          rst_n,
  vga_timing_if.master  vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS      = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS      = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START   = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START   = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END     = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic        frame_start;

  logic [10:0] hcount_next;
  logic [10:0] vcount_next;
  logic        hsync_next;
  logic        vsync_next;
  logic        hblnk_next;
  logic        vblnk_next;
  logic        frame_start_next;

  // Next raster position and the decodes for that position.
  always_comb begin
    hcount_next = hcount;
    vcount_next = vcount;
    if (hcount == H_LAST) begin
      hcount_next = 11'd0;
      if (vcount == V_LAST) begin
        vcount_next = 11'd0;
      end else begin
        vcount_next = vcount + 11'd1;
      end
    end else begin
      hcount_next = hcount + 11'd1;
    end

    hblnk_next = (hcount_next >= H_VIS);
    vblnk_next = (vcount_next >= V_VIS);

    if ((hcount_next >= HS_START) && (hcount_next < HS_END)) begin
      hsync_next = HSYNC_POL;
    end else begin
      hsync_next = ~HSYNC_POL;
    end

    // Depends only on the line number, so it switches at hcount = 0.
    if ((vcount_next >= VS_START) && (vcount_next < VS_END)) begin
      vsync_next = VSYNC_POL;
    end else begin
      vsync_next = ~VSYNC_POL;
    end

    frame_start_next = (hcount_next == 11'd0) && (vcount_next == 11'd0);
  end

  // Register counters and decodes together; reset parks at (0,0) with no pulse.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      hcount      <= 11'd0;
      vcount      <= 11'd0;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      frame_start <= 1'b0;
    end else begin
      hcount      <= hcount_next;
      vcount      <= vcount_next;
      hblnk       <= hblnk_next;
      vblnk       <= vblnk_next;
      hsync       <= hsync_next;
      vsync       <= vsync_next;
      frame_start <= frame_start_next;
    end
  end

  assign vga.hcount_out      = hcount;
  assign vga.vcount_out      = vcount;
  assign vga.hsync_out       = hsync;
  assign vga.vsync_out       = vsync;
  assign vga.hblnk_out       = hblnk;
  assign vga.vblnk_out       = vblnk;
  assign vga.frame_start_out = frame_start;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a default-timing instance (reset, line decode) and a
// tiny-timing instance (every cycle over many frames, mid-frame reset).
// Expected outputs are queued when the reset input is driven and popped
// after the following clock edge.
module tb_vga_timing;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic        fs;
  } exp_t;

  logic pclk;
  logic rst_big;
  logic rst_small;

  int n_checks;
  int n_fail;

  exp_t q_big[$];
  exp_t q_small[$];

  // model state: current position shown by each DUT
  int bh, bv, sh, sv;

  vga_timing_if big_if ();
  vga_timing_if small_if ();

  vga_timing dut_big (
    .pclk  (pclk),
    .rst_n (rst_big),
    .vga   (big_if.master)
  );

  vga_timing #(
    .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (2), .H_BACK (2),
    .V_VISIBLE (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
    .HSYNC_POL (1'b0), .VSYNC_POL (1'b0)
  ) dut_small (
    .pclk  (pclk),
    .rst_n (rst_small),
    .vga   (small_if.master)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: advance one edge for a timing set with active-low syncs.
  task automatic model_step(input int hv, input int hf, input int hsw, input int hbk,
                            input int vv, input int vf, input int vsw, input int vbk,
                            input logic rst, inout int mh, inout int mv, output exp_t e);
    int ht, vt;
    ht = hv + hf + hsw + hbk;
    vt = vv + vf + vsw + vbk;
    if (!rst) begin
      mh = 0; mv = 0;
      e = '{h: 11'd0, v: 11'd0, hs: 1'b1, vs: 1'b1, hb: 1'b0, vb: 1'b0, fs: 1'b0};
    end else begin
      mh = mh + 1;
      if (mh == ht) begin
        mh = 0;
        mv = (mv == vt - 1) ? 0 : mv + 1;
      end
      e.h  = 11'(mh);
      e.v  = 11'(mv);
      e.hb = (mh >= hv);
      e.vb = (mv >= vv);
      e.hs = !((mh >= hv + hf) && (mh < hv + hf + hsw));
      e.vs = !((mv >= vv + vf) && (mv < vv + vf + vsw));
      e.fs = (mh == 0) && (mv == 0);
    end
  endtask

  task automatic compare(input string pfx, input exp_t got, input exp_t e);
    check_val({pfx, ".hcount"}, 32'(got.h), 32'(e.h));
    check_val({pfx, ".vcount"}, 32'(got.v), 32'(e.v));
    check_val({pfx, ".hsync"},  32'(got.hs), 32'(e.hs));
    check_val({pfx, ".vsync"},  32'(got.vs), 32'(e.vs));
    check_val({pfx, ".hblnk"},  32'(got.hb), 32'(e.hb));
    check_val({pfx, ".vblnk"},  32'(got.vb), 32'(e.vb));
    check_val({pfx, ".fstart"}, 32'(got.fs), 32'(e.fs));
  endtask

  function automatic exp_t sample(input logic [10:0] h, input logic [10:0] v,
                                  input logic hs, input logic vs, input logic hb,
                                  input logic vb, input logic fs);
    exp_t r;
    r = '{h: h, v: v, hs: hs, vs: vs, hb: hb, vb: vb, fs: fs};
    return r;
  endfunction

  // statistics derived from observed outputs
  int  line_hs;
  bit  line_valid;
  int  fs_gap;
  int  fs_vs;
  bit  fs_valid;
  int  fs_pulses;
  int  cyc;
  bit  mid_done;

  task automatic run_cycle(input logic rb, input logic rs);
    exp_t e, got;
    @(negedge pclk);
    rst_big   = rb;
    rst_small = rs;
    model_step(1024, 24, 136, 160, 768, 3, 6, 29, rb, bh, bv, e);
    q_big.push_back(e);
    model_step(8, 2, 2, 2, 4, 1, 1, 1, rs, sh, sv, e);
    q_small.push_back(e);
    @(posedge pclk);
    #1;
    cyc++;

    got = sample(big_if.hcount_out, big_if.vcount_out, big_if.hsync_out,
                 big_if.vsync_out, big_if.hblnk_out, big_if.vblnk_out,
                 big_if.frame_start_out);
    if (q_big.size() == 0) begin
      check_val("big.queue_empty", 32'd1, 32'd0);
    end else begin
      compare("big", got, q_big.pop_front());
    end
    // hsync pulse width measured per full line
    if (!rb) begin
      line_valid = 1'b0;
      line_hs = 0;
    end else begin
      if (got.h == 11'd0) begin
        if (line_valid) check_val("big.hsync_width", 32'(line_hs), 32'd136);
        line_valid = 1'b1;
        line_hs = 0;
      end
      if (got.hs == 1'b0) line_hs++;
    end

    got = sample(small_if.hcount_out, small_if.vcount_out, small_if.hsync_out,
                 small_if.vsync_out, small_if.hblnk_out, small_if.vblnk_out,
                 small_if.frame_start_out);
    if (q_small.size() == 0) begin
      check_val("small.queue_empty", 32'd1, 32'd0);
    end else begin
      compare("small", got, q_small.pop_front());
    end
    // frame period and vsync duration measured between frame_start pulses
    if (!rs) begin
      fs_valid = 1'b0;
      fs_gap = 0;
      fs_vs = 0;
    end else begin
      if (got.fs) begin
        fs_pulses++;
        if (fs_valid) begin
          check_val("small.frame_period", 32'(fs_gap), 32'd98);
          check_val("small.vsync_cycles", 32'(fs_vs), 32'd14);
        end
        fs_valid = 1'b1;
        fs_gap = 0;
        fs_vs = 0;
      end
      fs_gap++;
      if (got.vs == 1'b0) fs_vs++;
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    bh = 0; bv = 0; sh = 0; sv = 0;
    line_hs = 0; line_valid = 1'b0;
    fs_gap = 0; fs_vs = 0; fs_valid = 1'b0; fs_pulses = 0;
    cyc = 0; mid_done = 1'b0;
    rst_big = 1'b0;
    rst_small = 1'b0;

    // hold reset for five cycles
    for (int i = 0; i < 5; i++) run_cycle(1'b0, 1'b0);

    // two full default lines plus a little; tiny instance runs many frames
    for (int i = 0; i < 2 * 1344 + 20; i++) begin
      if (!mid_done && cyc > 300 && sh == 5 && sv == 3) begin
        run_cycle(1'b1, 1'b0);
        mid_done = 1'b1;
      end else begin
        run_cycle(1'b1, 1'b1);
      end
    end

    check_val("mid_reset_applied", 32'(mid_done), 32'd1);
    check_val("small.fs_pulse_seen", 32'(fs_pulses > 10), 32'd1);
    check_val("big.final_vcount", 32'(big_if.vcount_out), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
# vga_timing

Free-running XGA timing generator at the head of the video pipeline. Produces the per-pixel position counters, sync and blanking signals consumed by draw_background and later drawing stages. All outputs are registered and mutually aligned: in any cycle they describe the same pixel. Default timing is 1024x768 @ 60 Hz on a 65 MHz pixel clock.

## Interface

Parameters:
- H_VISIBLE, 1024, active pixels per line
- H_FRONT, 24, horizontal front porch in pixels
- H_SYNC, 136, hsync pulse width in pixels
- H_BACK, 160, horizontal back porch in pixels (H_TOTAL = sum = 1344)
- V_VISIBLE, 768, active lines per frame
- V_FRONT, 3, vertical front porch in lines
- V_SYNC, 6, vsync pulse width in lines
- V_BACK, 29, vertical back porch in lines (V_TOTAL = sum = 806)
- HSYNC_POL, 0, active level of hsync_out
- VSYNC_POL, 0, active level of vsync_out

Ports:
- pclk  input  1  pixel clock; all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- hcount_out  output  11  horizontal position, 0..H_TOTAL-1
- vcount_out  output  11  vertical position, 0..V_TOTAL-1
- hsync_out  output  1  horizontal sync, active level HSYNC_POL
- vsync_out  output  1  vertical sync, active level VSYNC_POL
- hblnk_out  output  1  high when hcount_out >= H_VISIBLE
- vblnk_out  output  1  high when vcount_out >= V_VISIBLE
- frame_start_out  output  1  one-cycle pulse at pixel (0,0) of each frame

## Operation

- Decided: one clock; reset is synchronous and active-low.
- Horizontal counter: increments by 1 each cycle. At H_TOTAL-1, wraps to 0.
- Vertical counter: increments by 1 only on the horizontal wrap. When the horizontal counter wraps and vertical is at V_TOTAL-1, vertical wraps to 0.
- hblnk_out = (hcount_out >= H_VISIBLE). Default: 1024..1343.
- hsync_out active when H_VISIBLE+H_FRONT <= hcount_out < H_VISIBLE+H_FRONT+H_SYNC. Default: 1048..1183 inclusive.
- vblnk_out = (vcount_out >= V_VISIBLE) for the entire line, all hcount values. Default: 768..805.
- vsync_out active when V_VISIBLE+V_FRONT <= vcount_out < V_VISIBLE+V_FRONT+V_SYNC. Default: 771..776 inclusive. Changes only on line boundaries, aligned with hcount_out = 0.
- Inactive sync level = ~POL.
- frame_start_out = 1 exactly when hcount_out = 0 and vcount_out = 0, outside reset.
- Decode and alignment:
  - Sync, blank and frame_start are decoded from the next-counter values and registered alongside the counters.
  - This keeps them in the same cycle as the counters, with no combinational path from counters to outputs.
- Counter width: 11 bits. Parameters must satisfy H_TOTAL <= 2048 and V_TOTAL <= 2048, which the defaults do.

## Timing

- Reset: any pclk edge with rst_n = 0 loads:
  - hcount_out = 0, vcount_out = 0
  - hblnk_out = 0, vblnk_out = 0
  - hsync_out = ~HSYNC_POL, vsync_out = ~VSYNC_POL
  - frame_start_out = 0
- After reset:
  - First edge with rst_n = 1: hcount_out = 1, vcount_out = 0.
  - The first frame_start_out pulse occurs at the first wrap to (0,0), H_TOTAL*V_TOTAL edges later.
- Reset mid-frame: takes effect at the next edge, overrides counting, and returns to the reset state above. There is no partial-frame recovery.
- Line period is H_TOTAL cycles. Frame period is H_TOTAL*V_TOTAL cycles: 1,083,264 by default.
- The hsync pulse is exactly H_SYNC cycles per line. The vsync pulse is exactly V_SYNC*H_TOTAL cycles per frame.
- Latency to downstream: zero within this block. Each draw stage adds its own one-cycle register.

## Test plan

- Reset values: hold rst_n = 0 for 5 cycles. Expect counts 0, blanks 0, syncs 1 (POL = 0), frame_start_out 0. Release: next edge gives hcount_out = 1.
- Horizontal decode: over one line, hblnk_out rises at hcount_out = 1024. hsync_out is low for hcount_out 1048..1183 only, exactly 136 cycles. At hcount_out = 1343 the next cycle is hcount_out = 0 with vcount_out + 1.
- Vertical decode: vblnk_out is high from (0,768) through (1343,805). vsync_out is low from (0,771) through (1343,776), exactly 6*1344 cycles.
- Frame wrap: at (1343,805) the next cycle is (0,0) with frame_start_out = 1 for one cycle. Interval between pulses is 1,083,264 cycles.
- Mid-frame reset: assert rst_n = 0 at (500,400) for 1 cycle. Expect the reset state on the following edge, then counting resumes from (1,0). No frame_start_out until the next full wrap.
- Small parameters (H: 8/2/2/2, V: 4/1/1/1): check every cycle against a reference model over 3 frames.
